spm_ctrl_fsm: RTL

SPM_CTRL_FSM -- requirements
Module: spm_ctrl_fsm

---
 rtl/spm_ctrl_fsm.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spm_ctrl_fsm.sv
// Multi-cycle control FSM for the simple processor:
// fetch, decode and execute sequencing of datapath strobes.
module spm_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       zflag,
  output logic       load_r0,
  output logic       load_r1,
  output logic       load_r2,
  output logic       load_r3,
  output logic       load_pc,
  output logic       inc_pc,
  output logic       load_ir,
  output logic       load_add_r,
  output logic       load_reg_y,
  output logic       load_reg_z,
  output logic [2:0] sel_bus1,
  output logic [1:0] sel_bus2,
  output logic       write,
  output logic       halt,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_e;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  state_e state_q, state_d;

  logic [3:0] opcode;
  logic [1:0] src, dest;
  logic [3:0] ld_r;

  assign opcode = instr[7:4];
  assign src    = instr[3:2];
  assign dest   = instr[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ld_r       = 4'b0000;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    sel_bus1   = 3'd0;
    sel_bus2   = 2'd0;
    write      = 1'b0;
    halt       = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FET1;
      S_FET1: begin
        sel_bus1   = 3'd4;
        sel_bus2   = 2'd1;
        load_add_r = 1'b1;
        state_d    = S_FET2;
      end
      S_FET2: begin
        sel_bus2 = 2'd2;
        load_ir  = 1'b1;
        inc_pc   = 1'b1;
        state_d  = S_DEC;
      end
      S_DEC: begin
        case (opcode)
          OP_NOP: state_d = S_FET1;
          OP_ADD, OP_SUB, OP_AND: begin
            sel_bus1   = {1'b0, src};
            load_reg_y = 1'b1;
            state_d    = S_EX1;
          end
          OP_NOT: begin
            sel_bus1   = {1'b0, src};
            load_reg_z = 1'b1;
            ld_r[dest] = 1'b1;
            state_d    = S_FET1;
          end
          OP_RD, OP_WR, OP_BR: begin
            sel_bus1   = 3'd4;
            sel_bus2   = 2'd1;
            load_add_r = 1'b1;
            if (opcode == OP_RD)      state_d = S_RD1;
            else if (opcode == OP_WR) state_d = S_WR1;
            else                      state_d = S_BR1;
          end
          OP_BRZ: begin
            if (zflag) begin
              sel_bus1   = 3'd4;
              sel_bus2   = 2'd1;
              load_add_r = 1'b1;
              state_d    = S_BR1;
            end else begin
              // untaken: step over the operand byte
              inc_pc  = 1'b1;
              state_d = S_FET1;
            end
          end
          default: state_d = S_HALT;
        endcase
      end
      S_EX1: begin
        sel_bus1   = {1'b0, dest};
        load_reg_z = 1'b1;
        ld_r[dest] = 1'b1;
        state_d    = S_FET1;
      end
      S_RD1, S_WR1: begin
        sel_bus2   = 2'd2;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
      end
      S_RD2: begin
        sel_bus2   = 2'd2;
        ld_r[dest] = 1'b1;
        state_d    = S_FET1;
      end
      S_WR2: begin
        sel_bus1 = {1'b0, src};
        write    = 1'b1;
        state_d  = S_FET1;
      end
      S_BR1: begin
        sel_bus2   = 2'd2;
        load_add_r = 1'b1;
        state_d    = S_BR2;
      end
      S_BR2: begin
        sel_bus2 = 2'd2;
        load_pc  = 1'b1;
        state_d  = S_FET1;
      end
      S_HALT: halt = 1'b1;
      default: state_d = S_HALT;
    endcase
    // keep the datapath quiet for the whole reset cycle
    if (!rst_n) begin
      ld_r       = 4'b0000;
      load_pc    = 1'b0;
      inc_pc     = 1'b0;
      load_ir    = 1'b0;
      load_add_r = 1'b0;
      load_reg_y = 1'b0;
      load_reg_z = 1'b0;
      sel_bus1   = 3'd0;
      sel_bus2   = 2'd0;
      write      = 1'b0;
      halt       = 1'b0;
    end
  end

  assign load_r0   = ld_r[0];
  assign load_r1   = ld_r[1];
  assign load_r2   = ld_r[2];
  assign load_r3   = ld_r[3];
  assign state_dbg = rst_n ? state_q : 4'd0;

endmodule
